// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Holds the FSM state encoding and a lowest-set-bit helper.
package rst_seq_pkg;

    localparam int MAX_DOMAINS = 8;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        IDLE
    } rst_seq_state_t;

    // One-hot of the lowest set bit of v (zero when v is zero).
    function automatic logic [MAX_DOMAINS-1:0] lowest_set_idx(
        input logic [MAX_DOMAINS-1:0] v
    );
        return v & (~v + {{(MAX_DOMAINS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds N_DOMAINS resets, releases them in ascending
// order with a programmable gap, optional cascading, sticky cause flags.
// Ports:
//   clk          system clock
//   rstn_i       synchronous active-low reset
//   rst_req_i    per-domain active-high reset request (level)
//   cause_clr_i  one-cycle pulse clearing rst_cause_o
//   rstn_o       registered active-low domain resets
//   busy_o       high while any domain is held or pending release
//   rst_cause_o  sticky per-domain request-caused-reset flags
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_DOMAINS   = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int CASCADE     = 1
) (
    input  logic                 clk,
    input  logic                 rstn_i,
    input  logic [N_DOMAINS-1:0] rst_req_i,
    input  logic                 cause_clr_i,
    output logic [N_DOMAINS-1:0] rstn_o,
    output logic                 busy_o,
    output logic [N_DOMAINS-1:0] rst_cause_o
);

    localparam int CNT_MAX =
        (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    // The first edge with all requests low already counts, so the hold
    // terminal count sits one above HOLD_CYCLES-1. This gives a release
    // HOLD_CYCLES edges after that first low edge and a minimum low pulse
    // of HOLD_CYCLES+1 cycles.
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES - 1);

    rst_seq_state_t       state_q, state_d;
    logic [N_DOMAINS-1:0] p_q, p_d;
    logic [N_DOMAINS-1:0] cause_q, cause_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    logic [N_DOMAINS-1:0]   casc_mask;
    logic [N_DOMAINS-1:0]   req_mask;
    logic                   req_any;
    logic [MAX_DOMAINS-1:0] p_wide;
    logic [MAX_DOMAINS-1:0] low_wide;
    logic [N_DOMAINS-1:0]   p_clr;

    // Cascade: every bit at or above the lowest requested bit.
    always_comb begin
        logic acc;
        acc       = 1'b0;
        casc_mask = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            acc          = acc | rst_req_i[i];
            casc_mask[i] = acc;
        end
    end

    assign req_mask = (CASCADE != 0) ? casc_mask : rst_req_i;
    assign req_any  = |rst_req_i;

    assign p_wide   = MAX_DOMAINS'(p_q);
    assign low_wide = lowest_set_idx(p_wide);
    assign p_clr    = p_q & ~low_wide[N_DOMAINS-1:0];

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        cause_d = cause_clr_i ? '0 : cause_q;

        if (req_any) begin
            // Any request (re)starts the hold from every state.
            p_d     = p_q | req_mask;
            cause_d = cause_d | req_mask;
            cnt_d   = '0;
            state_d = HOLD;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_END) begin
                        p_d     = p_clr;
                        cnt_d   = '0;
                        state_d = (p_clr == '0) ? IDLE : RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_END) begin
                        p_d   = p_clr;
                        cnt_d = '0;
                        if (p_clr == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                IDLE: begin
                end
                default: begin
                    state_d = HOLD;
                    p_d     = '1;
                    cnt_d   = '0;
                end
            endcase
        end

        // Busy is its own flop so it cannot glitch on multi-bit state changes.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q <= HOLD;
            p_q     <= '1;
            cnt_q   <= '0;
            cause_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            busy_q  <= busy_d;
        end
    end

    assign rstn_o      = ~p_q;
    assign busy_o      = busy_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Testbench for rst_sequencer: cascade and non-cascade instances
// driven in parallel, directed scenarios plus a randomized model check.
module tb_rst_sequencer;

    localparam int N = 3;
    localparam int H = 4;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] req;
    logic         clr;

    logic [N-1:0] a_rstn, b_rstn, a_cause, b_cause;
    logic         a_busy, b_busy;

    always #5 clk = ~clk;

    rst_sequencer #(
        .N_DOMAINS(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CASCADE(1)
    ) u_a (
        .clk(clk), .rstn_i(rstn), .rst_req_i(req), .cause_clr_i(clr),
        .rstn_o(a_rstn), .busy_o(a_busy), .rst_cause_o(a_cause)
    );

    rst_sequencer #(
        .N_DOMAINS(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CASCADE(0)
    ) u_b (
        .clk(clk), .rstn_i(rstn), .rst_req_i(req), .cause_clr_i(clr),
        .rstn_o(b_rstn), .busy_o(b_busy), .rst_cause_o(b_cause)
    );

    logic [N-1:0] o_rstn  [2];
    logic [N-1:0] o_cause [2];
    logic         o_busy  [2];

    assign o_rstn[0]  = a_rstn;
    assign o_rstn[1]  = b_rstn;
    assign o_cause[0] = a_cause;
    assign o_cause[1] = b_cause;
    assign o_busy[0]  = a_busy;
    assign o_busy[1]  = b_busy;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: pending set, cause flags and the absolute edge
    // number at which the next release is due. Index 0 cascades.
    logic [N-1:0] m_p     [2];
    logic [N-1:0] m_cause [2];
    int           m_dl    [2];

    function automatic logic [N-1:0] expand(
        input logic [N-1:0] r, input bit casc
    );
        logic [N-1:0] low;
        if (!casc || r == '0) return r;
        low = r & (~r + N'(1));
        return ~(low - N'(1));
    endfunction

    task automatic step();
        logic [N-1:0] mask;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                m_p[i]     = '1;
                m_cause[i] = '0;
                m_dl[i]    = edge_n + 1 + H;
            end else if (req != '0) begin
                mask       = expand(req, i == 0);
                m_p[i]     = m_p[i] | mask;
                m_cause[i] = (clr ? '0 : m_cause[i]) | mask;
                m_dl[i]    = edge_n + 1 + H;
            end else begin
                if (clr) m_cause[i] = '0;
                if (m_p[i] != '0 && edge_n == m_dl[i]) begin
                    m_p[i]  = m_p[i] & (m_p[i] - N'(1));
                    m_dl[i] = edge_n + G;
                end
            end
        end
        edge_n++;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req  = '0;
        clr  = 1'b0;
        repeat (5) step();
        checks++;
        if ({a_rstn, a_busy, a_cause} !== {3'b000, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset_a got %b/%b/%b want 000/1/000",
                     a_rstn, a_busy, a_cause);
        end
        checks++;
        if ({b_rstn, b_busy, b_cause} !== {3'b000, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset_b got %b/%b/%b want 000/1/000",
                     b_rstn, b_busy, b_cause);
        end
    endtask

    task automatic test_powerup();
        logic [N-1:0] e;
        logic         eb;
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            e  = (k < 4) ? 3'b000 : (k < 6) ? 3'b001 :
                 (k < 8) ? 3'b011 : 3'b111;
            eb = (k < 8);
            checks++;
            if ({a_rstn, a_busy, a_cause} !== {e, eb, 3'b000}) begin
                errors++;
                $display("FAIL powerup_a E0+%0d got %b/%b/%b want %b/%b/000",
                         k, a_rstn, a_busy, a_cause, e, eb);
            end
            checks++;
            if ({b_rstn, b_busy, b_cause} !== {e, eb, 3'b000}) begin
                errors++;
                $display("FAIL powerup_b E0+%0d got %b/%b/%b want %b/%b/000",
                         k, b_rstn, b_busy, b_cause, e, eb);
            end
        end
    endtask

    task automatic test_cascade();
        logic [N-1:0] ea, eb;
        req = 3'b010;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({a_rstn, a_cause} !== {3'b001, 3'b110}) begin
                errors++;
                $display("FAIL cascade_hold_a got %b/%b want 001/110",
                         a_rstn, a_cause);
            end
            checks++;
            if ({b_rstn, b_cause} !== {3'b101, 3'b010}) begin
                errors++;
                $display("FAIL cascade_hold_b got %b/%b want 101/010",
                         b_rstn, b_cause);
            end
        end
        req = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            ea = (k < 4) ? 3'b001 : (k < 6) ? 3'b011 : 3'b111;
            eb = (k < 4) ? 3'b101 : 3'b111;
            checks++;
            if (a_rstn !== ea) begin
                errors++;
                $display("FAIL cascade_rel_a r+%0d got %b want %b",
                         k, a_rstn, ea);
            end
            checks++;
            if (b_rstn !== eb) begin
                errors++;
                $display("FAIL cascade_rel_b r+%0d got %b want %b",
                         k, b_rstn, eb);
            end
        end
    endtask

    task automatic test_noncascade();
        logic [N-1:0] e;
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if ({a_cause, b_cause} !== 6'b000000) begin
            errors++;
            $display("FAIL cause_clear got %b/%b want 000/000",
                     a_cause, b_cause);
        end
        req = 3'b100;
        step();
        req = '0;
        for (int k = 1; k < 7; k++) begin
            step();
            e = (k < 5) ? 3'b011 : 3'b111;
            checks++;
            if ({b_rstn, b_busy} !== {e, (k < 5)}) begin
                errors++;
                $display("FAIL noncascade_b t+%0d got %b/%b want %b/%b",
                         k + 1, b_rstn, b_busy, e, (k < 5));
            end
            checks++;
            if (a_rstn !== e) begin
                errors++;
                $display("FAIL noncascade_a t+%0d got %b want %b",
                         k + 1, a_rstn, e);
            end
        end
    endtask

    task automatic test_rerequest();
        logic [N-1:0] ea, eb;
        req = 3'b001;
        step();
        req = '0;
        repeat (5) step();
        checks++;
        if ({a_rstn, b_rstn} !== {3'b001, 3'b111}) begin
            errors++;
            $display("FAIL rereq_first got %b/%b want 001/111",
                     a_rstn, b_rstn);
        end
        req = 3'b001;
        step();
        req = '0;
        checks++;
        if ({a_rstn, b_rstn} !== {3'b000, 3'b110}) begin
            errors++;
            $display("FAIL rereq_assert got %b/%b want 000/110",
                     a_rstn, b_rstn);
        end
        for (int k = 1; k < 10; k++) begin
            step();
            ea = (k < 5) ? 3'b000 : (k < 7) ? 3'b001 :
                 (k < 9) ? 3'b011 : 3'b111;
            eb = (k < 5) ? 3'b110 : 3'b111;
            checks++;
            if ({a_rstn, b_rstn} !== {ea, eb}) begin
                errors++;
                $display("FAIL rereq_seq t+%0d got %b/%b want %b/%b",
                         k, a_rstn, b_rstn, ea, eb);
            end
        end
    endtask

    task automatic test_midreset();
        req = 3'b001;
        step();
        req = '0;
        repeat (7) step();
        checks++;
        if (a_rstn !== 3'b011) begin
            errors++;
            $display("FAIL midreset_pre got %b want 011", a_rstn);
        end
        rstn = 1'b0;
        req  = 3'b111;
        clr  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({a_rstn, a_busy, a_cause, b_rstn, b_busy, b_cause} !==
                {3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 3'b000}) begin
                errors++;
                $display("FAIL midreset_hold got %b/%b/%b %b/%b/%b want 000/1/000",
                         a_rstn, a_busy, a_cause, b_rstn, b_busy, b_cause);
            end
        end
        rstn = 1'b1;
        req  = '0;
        clr  = 1'b0;
        repeat (H + 2 * G + 1) step();
        checks++;
        if ({a_rstn, a_busy, a_cause, b_rstn, b_busy, b_cause} !==
            {3'b111, 1'b0, 3'b000, 3'b111, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL midreset_after got %b/%b/%b %b/%b/%b want 111/0/000",
                     a_rstn, a_busy, a_cause, b_rstn, b_busy, b_cause);
        end
    endtask

    task automatic test_clr_race();
        req = 3'b011;
        step();
        req = '0;
        checks++;
        if ({a_cause, b_cause} !== {3'b111, 3'b011}) begin
            errors++;
            $display("FAIL race_pre got %b/%b want 111/011",
                     a_cause, b_cause);
        end
        clr = 1'b1;
        req = 3'b100;
        step();
        clr = 1'b0;
        req = '0;
        checks++;
        if ({a_cause, b_cause} !== {3'b100, 3'b100}) begin
            errors++;
            $display("FAIL race_set_wins got %b/%b want 100/100",
                     a_cause, b_cause);
        end
        repeat (12) step();
        checks++;
        if ({a_rstn, a_busy, b_rstn, b_busy} !==
            {3'b111, 1'b0, 3'b111, 1'b0}) begin
            errors++;
            $display("FAIL race_settle got %b/%b %b/%b want 111/0",
                     a_rstn, a_busy, b_rstn, b_busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rstn = ($urandom_range(0, 63) != 0);
            req  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            clr  = ($urandom_range(0, 7) == 0);
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({o_rstn[i], o_busy[i], o_cause[i]} !==
                    {~m_p[i], |m_p[i], m_cause[i]}) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got %b/%b/%b want %b/%b/%b",
                             i, c, o_rstn[i], o_busy[i], o_cause[i],
                             ~m_p[i], |m_p[i], m_cause[i]);
                end
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        req  = '0;
        clr  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_p[i]     = '1;
            m_cause[i] = '0;
            m_dl[i]    = 0;
        end
        test_reset();
        test_powerup();
        test_cascade();
        test_noncascade();
        test_rerequest();
        test_midreset();
        test_clr_race();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
